vec_field_unit: RTL and testbench

VEC_FIELD_UNIT -- requirements
Module: vec_field_unit

---
 rtl/vec_field_pkg.sv | 19 +
 rtl/vec_field_mask.sv | 29 ++
 rtl/vec_field_unit.sv | 110 +++++++++++
 tb/tb_vec_field_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_field_pkg.sv
// Shared types and constants for the bit-field unit: operation codes,
// handshake FSM states and the request counter width.
package vec_field_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    OP_EXTRACT   = 2'd0,
    OP_INSERT    = 2'd1,
    OP_REPLICATE = 2'd2,
    OP_NOP       = 2'd3
  } field_op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } field_state_t;

endpackage

// File: rtl/vec_field_mask.sv
// Combinational field mask: ones over bits [off +: len], truncated at the word
// top, with a flag raised when the requested field runs past bit WIDTH-1.
module vec_field_mask #(
  parameter int WIDTH = 8,
  parameter int OFF_W = $clog2(WIDTH),
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic [OFF_W-1:0] i_off,
  input  logic [LEN_W-1:0] i_len,
  output logic [WIDTH-1:0] o_mask,
  output logic             o_clip
);

  // One extra bit so off+len never wraps.
  localparam int EW = LEN_W + 1;

  logic [EW-1:0] w_end;

  always_comb begin
    w_end  = EW'(i_off) + EW'(i_len);
    o_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_mask[i] = (EW'(i) >= EW'(i_off)) && (EW'(i) < w_end);
    end
    // An empty field is never reported as clipped.
    o_clip = (w_end > EW'(WIDTH)) && (i_len != '0);
  end

endmodule

// File: rtl/vec_field_unit.sv
// Single-stage bit-field unit (extract / insert / replicate / pass-through)
// with a one-entry valid/ready output register and an accepted-request counter.
module vec_field_unit
  import vec_field_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OFF_W = $clog2(WIDTH),
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  field_op_t          in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [OFF_W-1:0]   in_off,
  input  logic [LEN_W-1:0]   in_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic [CNT_W-1:0]   op_count,
  output field_state_t       dbg_state
);

  // Handshake: a transfer happens on any edge where valid && ready are both 1.
  // The input side is ready whenever the output register is empty or is being
  // drained this cycle; out_data/out_err hold while out_valid && !out_ready.

  logic [WIDTH-1:0] w_mask;
  logic             w_clip;
  logic [WIDTH-1:0] w_result;
  logic             w_accept;

  field_state_t     r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic [CNT_W-1:0] r_op_count;

  vec_field_mask #(
    .WIDTH (WIDTH),
    .OFF_W (OFF_W),
    .LEN_W (LEN_W)
  ) u_mask (
    .i_off  (in_off),
    .i_len  (in_len),
    .o_mask (w_mask),
    .o_clip (w_clip)
  );

  always_comb begin
    w_result = in_a;
    case (in_op)
      OP_EXTRACT:   w_result = (in_a & w_mask) >> in_off;
      OP_INSERT:    w_result = (in_a & ~w_mask) | ((in_b << in_off) & w_mask);
      OP_REPLICATE: w_result = in_b[0] ? (in_a | w_mask) : (in_a & ~w_mask);
      default:      w_result = in_a;
    endcase
  end

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_err   <= w_clip;
            r_op_count  <= r_op_count + 1'b1;
          end
        end
        ST_FULL: begin
          if (w_accept) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_err   <= w_clip;
            r_op_count  <= r_op_count + 1'b1;
          end else if (out_ready) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;
  assign op_count  = r_op_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_vec_field_unit.sv
// Directed bench for vec_field_unit at WIDTH = 8: field operations, clipping,
// backpressure, counter wrap and reset while a result is pending.
module tb_vec_field_unit;
  import vec_field_pkg::*;

  localparam int WIDTH = 8;
  localparam int OFF_W = 3;
  localparam int LEN_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  field_op_t        in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OFF_W-1:0] in_off;
  logic [LEN_W-1:0] in_len;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [15:0]      op_count;
  field_state_t     dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vec_field_unit #(
    .WIDTH (WIDTH),
    .OFF_W (OFF_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_off    (in_off),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .op_count  (op_count),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one request for exactly one edge with out_ready = 1, then
  // return what is visible at the following falling edge.
  task automatic drive_one(input field_op_t op, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] off,
                           input logic [3:0] len,
                           output logic v, output logic [7:0] d,
                           output logic e);
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_off    = off;
    in_len    = len;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    v = out_valid;
    d = out_data;
    e = out_err;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_op = OP_NOP;
    in_a = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, out_data, out_err, op_count, in_ready} !== {1'b0, 8'h00, 1'b0, 16'h0000, 1'b1}) begin
      $display("FAIL reset_state: got v=%0b d=%h e=%0b cnt=%h rdy=%0b, need 0 00 0 0000 1",
               out_valid, out_data, out_err, op_count, in_ready);
    end else pass_cnt++;
    total_cnt++;
    if (dbg_state !== ST_EMPTY) $display("FAIL reset_fsm: got %0d need EMPTY", dbg_state);
    else pass_cnt++;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_extract();
    logic v, e;
    logic [7:0] d;
    drive_one(OP_EXTRACT, 8'b1111_0101, 8'h00, 3'd2, 4'd2, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'h01, 1'b0})
      $display("FAIL extract_basic: got v=%0b d=%h e=%0b need 1 01 0", v, d, e);
    else pass_cnt++;
    total_cnt++;
    if (op_count !== 16'd1) $display("FAIL extract_count: got %h need 0001", op_count);
    else pass_cnt++;
    // Drain: out_ready stays 1 with no new request, so out_valid must fall.
    @(negedge clk);
    total_cnt++;
    if ({out_valid, dbg_state} !== {1'b0, ST_EMPTY})
      $display("FAIL drain: got v=%0b st=%0d need 0 EMPTY", out_valid, dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_insert();
    logic v, e;
    logic [7:0] d;
    drive_one(OP_INSERT, 8'h00, 8'h0F, 3'd4, 4'd4, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'hF0, 1'b0})
      $display("FAIL insert_hi: got v=%0b d=%h e=%0b need 1 f0 0", v, d, e);
    else pass_cnt++;
    drive_one(OP_INSERT, 8'h0E, 8'h7F, 3'd0, 4'd4, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'h0F, 1'b0})
      $display("FAIL insert_lo: got v=%0b d=%h e=%0b need 1 0f 0", v, d, e);
    else pass_cnt++;
    drive_one(OP_INSERT, 8'h3C, 8'hFF, 3'd2, 4'd0, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'h3C, 1'b0})
      $display("FAIL insert_len0: got v=%0b d=%h e=%0b need 1 3c 0", v, d, e);
    else pass_cnt++;
    drive_one(OP_INSERT, 8'h00, 8'hFF, 3'd5, 4'd5, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'hE0, 1'b1})
      $display("FAIL insert_clip: got v=%0b d=%h e=%0b need 1 e0 1", v, d, e);
    else pass_cnt++;
  endtask

  task automatic test_clip();
    logic v, e;
    logic [7:0] d;
    drive_one(OP_EXTRACT, 8'hFF, 8'h00, 3'd6, 4'd4, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'h03, 1'b1})
      $display("FAIL extract_clip: got v=%0b d=%h e=%0b need 1 03 1", v, d, e);
    else pass_cnt++;
    drive_one(OP_EXTRACT, 8'hFF, 8'h00, 3'd6, 4'd0, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL extract_len0: got v=%0b d=%h e=%0b need 1 00 0", v, d, e);
    else pass_cnt++;
    drive_one(OP_EXTRACT, 8'hA5, 8'h00, 3'd0, 4'd8, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'hA5, 1'b0})
      $display("FAIL extract_full: got v=%0b d=%h e=%0b need 1 a5 0", v, d, e);
    else pass_cnt++;
  endtask

  task automatic test_replicate_nop();
    logic v, e;
    logic [7:0] d;
    drive_one(OP_REPLICATE, 8'h00, 8'h01, 3'd1, 4'd3, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'h0E, 1'b0})
      $display("FAIL repl_ones: got v=%0b d=%h e=%0b need 1 0e 0", v, d, e);
    else pass_cnt++;
    drive_one(OP_REPLICATE, 8'hFF, 8'hFE, 3'd4, 4'd4, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'h0F, 1'b0})
      $display("FAIL repl_zeros: got v=%0b d=%h e=%0b need 1 0f 0", v, d, e);
    else pass_cnt++;
    drive_one(OP_NOP, 8'hA5, 8'h5A, 3'd3, 4'd2, v, d, e);
    total_cnt++;
    if ({v, d, e} !== {1'b1, 8'hA5, 1'b0})
      $display("FAIL nop: got v=%0b d=%h e=%0b need 1 a5 0", v, d, e);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] c0;
    c0 = op_count;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = OP_EXTRACT;
    in_a      = 8'b1111_0101;
    in_off    = 3'd2;
    in_len    = 4'd2;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({in_ready, out_valid, out_data, op_count, dbg_state} !== {1'b0, 1'b1, 8'h01, c0 + 16'd1, ST_FULL})
        $display("FAIL hold_%0d: got rdy=%0b v=%0b d=%h cnt=%h st=%0d need 0 1 01 %h FULL",
                 k, in_ready, out_valid, out_data, op_count, dbg_state, c0 + 16'd1);
      else pass_cnt++;
      in_a = 8'hC3 ^ 8'(k);  // changing input must not leak through while stalled
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, in_ready, op_count} !== {1'b0, 1'b1, c0 + 16'd1})
      $display("FAIL release: got v=%0b rdy=%0b cnt=%h need 0 1 %h",
               out_valid, in_ready, op_count, c0 + 16'd1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_op     = OP_NOP;
    in_a      = 8'h77;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({op_count, out_valid, in_ready} !== {16'hFFFF, 1'b1, 1'b1})
      $display("FAIL count_ffff: got cnt=%h v=%0b rdy=%0b need ffff 1 1", op_count, out_valid, in_ready);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({op_count, out_valid, out_data} !== {16'h0001, 1'b1, 8'h77})
      $display("FAIL count_wrap: got cnt=%h v=%0b d=%h need 0001 1 77", op_count, out_valid, out_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_pending();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_a     = 8'h99;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, op_count, out_data, in_ready, dbg_state} !== {1'b0, 16'h0000, 8'h00, 1'b1, ST_EMPTY})
      $display("FAIL reset_pending: got v=%0b cnt=%h d=%h rdy=%0b st=%0d need 0 0000 00 1 EMPTY",
               out_valid, op_count, out_data, in_ready, dbg_state);
    else pass_cnt++;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({out_valid, op_count} !== {1'b0, 16'h0000})
      $display("FAIL after_reset: got v=%0b cnt=%h need 0 0000", out_valid, op_count);
    else pass_cnt++;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_op     = OP_NOP;
    in_a      = '0;
    in_b      = '0;
    in_off    = '0;
    in_len    = '0;
    test_reset();
    test_extract();
    test_insert();
    test_clip();
    test_replicate_nop();
    test_backpressure();
    test_back_to_back();
    test_reset_pending();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
